// File: rtl/alu_div_pkg.sv
// -----------------------------------------------------------------------------
// alu_div_pkg
// Shared definitions for the sequential signed divider that sits beside the
// combinational multiplier in the ALU.
//   DIV_WIDTH      default operand/result width (also the iteration count)
//   div_state_e    divider FSM states
//   div_cnt_width  width of the iteration counter for a given operand width
// The divide-by-zero quotient is all ones at whatever width the divider is
// built for, so it is written as '1 at the point of use.
// -----------------------------------------------------------------------------
package alu_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_DIVIDE = 2'd1,
        DIV_FIXUP  = 2'd2,
        DIV_DONE   = 2'd3
    } div_state_e;

    // The counter has to reach WIDTH itself, hence the +1.
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/alu_div_if.sv
// -----------------------------------------------------------------------------
// alu_div_if
// Request/result bundle between the ALU control unit and the divider.
//   start     begin a division (sampled only while the divider is idle)
//   A, B      signed dividend / divisor
//   LO, HI    signed quotient / remainder (multiplier HI/LO convention)
//   busy      operation in flight; control unit stalls on it
//   done      one-cycle pulse when LO/HI have just been written
//   div_zero  last operation had a zero divisor
// master: the requester (control unit / bench); slave: the divider.
// -----------------------------------------------------------------------------
interface alu_div_if #(
    parameter int WIDTH = alu_div_pkg::DIV_WIDTH
);
    logic                    start;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic signed [WIDTH-1:0] LO;
    logic signed [WIDTH-1:0] HI;
    logic                    busy;
    logic                    done;
    logic                    div_zero;

    modport master (
        output start, A, B,
        input  LO, HI, busy, done, div_zero
    );

    modport slave (
        input  start, A, B,
        output LO, HI, busy, done, div_zero
    );
endinterface

// File: rtl/alu_div_step.sv
// -----------------------------------------------------------------------------
// alu_div_step
// One combinational restoring-division step on unsigned magnitudes.
//   rem_i   partial remainder (always < dvsr_i, so WIDTH bits suffice)
//   quo_i   remaining dividend bits / quotient bits built so far
//   dvsr_i  divisor magnitude (up to 2^(WIDTH-1), exact as unsigned)
//   rem_o   next partial remainder
//   quo_o   next dividend/quotient word, new quotient bit in bit 0
// -----------------------------------------------------------------------------
module alu_div_step
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Shift the remainder:quotient pair left by one; the shifted
        // remainder needs one extra bit before the trial subtract.
        shifted = {rem_i, quo_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvsr_i});
        // When the divisor fits, the difference is below dvsr_i and
        // therefore representable in WIDTH bits, so the top bit can be dropped.
        diff    = shifted[WIDTH-1:0] - dvsr_i;
        rem_o   = fits ? diff : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/alu_div.sv
// -----------------------------------------------------------------------------
// alu_div
// Sequential signed restoring divider, WIDTH iterations per operation.
// Quotient goes to LO and remainder to HI, truncating toward zero with the
// remainder taking the dividend's sign (A == LO*B + HI, |HI| < |B|).
//   clock    rising-edge clock
//   clear_n  synchronous active-low reset
//   bus      alu_div_if slave: start/A/B in, LO/HI/busy/done/div_zero out
// Timing from the accepting edge E0: DIVIDE on E1..E_WIDTH, FIXUP writes
// LO/HI on E_WIDTH+1, done is high for the following cycle.  A zero
// divisor skips DIVIDE and writes its results on E1.
// -----------------------------------------------------------------------------
module alu_div
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clock,
    input  logic       clear_n,
    alu_div_if.slave   bus
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [WIDTH-1:0]        dvsr_q, dvsr_d;
    logic                    sgn_quo_q, sgn_quo_d;
    logic                    sgn_rem_q, sgn_rem_d;
    logic                    dz_q, dz_d;
    logic signed [WIDTH-1:0] lo_q, lo_d;
    logic signed [WIDTH-1:0] hi_q, hi_d;
    logic                    div_zero_q, div_zero_d;

    logic [WIDTH-1:0]        step_rem;
    logic [WIDTH-1:0]        step_quo;

    // Two's-complement magnitude as an unsigned WIDTH-bit value.  The most
    // negative input maps to 2^(WIDTH-1), which is exact when read unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Re-apply a sign to an unsigned magnitude.  A quotient magnitude of
    // 2^(WIDTH-1) with a positive sign wraps to the most negative value,
    // which is the intended result for MIN / -1.
    function automatic logic [WIDTH-1:0] apply_sign(input logic neg,
                                                    input logic [WIDTH-1:0] mag);
        return neg ? -mag : mag;
    endfunction

    alu_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        sgn_quo_d  = sgn_quo_q;
        sgn_rem_d  = sgn_rem_q;
        dz_d       = dz_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (bus.start) begin
                    dvsr_d     = magnitude(bus.B);
                    sgn_quo_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    sgn_rem_d  = bus.A[WIDTH-1];
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    if (bus.B == '0) begin
                        // Park |A| in the remainder so FIXUP's sign path
                        // reproduces A on HI without a separate mux.
                        dz_d    = 1'b1;
                        rem_d   = magnitude(bus.A);
                        quo_d   = '0;
                        state_d = DIV_FIXUP;
                    end else begin
                        dz_d    = 1'b0;
                        rem_d   = '0;
                        quo_d   = magnitude(bus.A);
                        state_d = DIV_DIVIDE;
                    end
                end
            end
            DIV_DIVIDE: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_FIXUP;
                end
            end
            DIV_FIXUP: begin
                lo_d       = dz_q ? '1 : apply_sign(sgn_quo_q, quo_q);
                hi_d       = apply_sign(sgn_rem_q, rem_q);
                div_zero_d = dz_q;
                state_d    = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            sgn_quo_q  <= 1'b0;
            sgn_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            sgn_quo_q  <= sgn_quo_d;
            sgn_rem_q  <= sgn_rem_d;
            dz_q       <= dz_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            div_zero_q <= div_zero_d;
        end
    end

    // busy covers FIXUP and DONE as well, so it drops together with done.
    assign bus.busy     = (state_q != DIV_IDLE);
    assign bus.done     = (state_q == DIV_DONE);
    assign bus.LO       = lo_q;
    assign bus.HI       = hi_q;
    assign bus.div_zero = div_zero_q;

endmodule
